// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths, MMIO base and arbiter FSM encodings
package dmem_arbiter_pkg;
  localparam int DMEM_DBITS = 32;
  localparam int DMEM_STARVE_LIMIT = 4;
  localparam logic [31:0] DMEM_MMIO_BASE = 32'hF000_0000;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} arb_state_t;
endpackage

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr: saturating count of denied secondary cycles
module dmem_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  logic [3:0] cnt;
  assign at_limit = cnt == 4'(LIMIT);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc && !at_limit) cnt <= cnt + 4'd1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/secondary data-memory arbiter; DMEM_ARB_MMIO_PROTECT_EN blocks secondary MMIO access
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DBITS = DMEM_DBITS,
  parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT,
  parameter logic [DBITS-1:0] MMIO_BASE = DMEM_MMIO_BASE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_wr,
  input  logic [DBITS-1:0] cpu_addr,
  input  logic [DBITS-1:0] cpu_wdata,
  output logic [DBITS-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             sec_req,
  input  logic             sec_wr,
  input  logic [DBITS-1:0] sec_addr,
  input  logic [DBITS-1:0] sec_wdata,
  output logic             sec_ack,
  output logic [DBITS-1:0] sec_rdata,
  output logic             mem_en_write,
  output logic [DBITS-3:0] mem_addr,
  output logic [DBITS-1:0] mem_data_in,
  input  logic [DBITS-1:0] mem_data_out
);
`ifdef DMEM_ARB_MMIO_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif
  arb_state_t state;
  logic at_limit, sec_gnt, cpu_gnt, blocked, unused_bits;
  // sec_req is part of the grant so a request withdrawn in WAIT never touches memory
  assign sec_gnt = state == WAIT && sec_req && (!cpu_req || at_limit);
  assign cpu_gnt = cpu_req && !sec_gnt;
  assign blocked = PROTECT && sec_addr >= MMIO_BASE;
  assign cpu_stall = cpu_req && sec_gnt;
  assign cpu_rdata = cpu_gnt ? mem_data_out : '0;
  assign mem_en_write = sec_gnt ? sec_wr && !blocked : cpu_gnt && cpu_wr;
  assign mem_addr = sec_gnt ? sec_addr[DBITS-1:2] : cpu_addr[DBITS-1:2];
  assign mem_data_in = sec_gnt ? sec_wdata : cpu_wdata;
  assign sec_ack = state == ACK;
  assign unused_bits = ^{cpu_addr[1:0], sec_addr[1:0]};
  dmem_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk),
    .reset(reset),
    .inc(state == WAIT && sec_req && !sec_gnt),
    .clr(state != WAIT || !sec_req || sec_gnt),
    .at_limit(at_limit)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      sec_rdata <= '0;
    end else begin
      if (sec_gnt) sec_rdata <= sec_wr || blocked ? '0 : mem_data_out;
      case (state)
        IDLE: state <= sec_req ? WAIT : IDLE;
        WAIT: state <= sec_gnt ? ACK : sec_req ? WAIT : IDLE;
        ACK: state <= sec_req ? WAIT : IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;
  logic clk = 0, reset, cpu_req, cpu_wr, cpu_stall, sec_req, sec_wr, sec_ack, mem_en_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, sec_addr, sec_wdata, sec_rdata, mem_data_in, mem_data_out;
  logic [29:0] mem_addr;
  logic [31:0] mem [0:255];
  logic [31:0] sb [$];
  int n_cmp = 0, n_fail = 0;
`ifdef DMEM_ARB_MMIO_PROTECT_EN
  localparam logic MMIO_WE = 1'b0;
`else
  localparam logic MMIO_WE = 1'b1;
`endif

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .sec_req(sec_req), .sec_wr(sec_wr), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
    .sec_ack(sec_ack), .sec_rdata(sec_rdata),
    .mem_en_write(mem_en_write), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  assign mem_data_out = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_en_write) mem[mem_addr[7:0]] <= mem_data_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (sec_ack) begin
      chk("ack_has_pending_txn", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("sec_rdata", sec_rdata, sb.pop_front());
    end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1; cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    sec_req = 1; sec_wr = 0; sec_addr = 0; sec_wdata = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_sec_ack", sec_ack, 0);
      chk("rst_cpu_stall", cpu_stall, 0);
      chk("rst_mem_en_write", mem_en_write, 0);
      chk("rst_sec_rdata", sec_rdata, 0);
    end
    reset = 0; sec_req = 0;
    tick();
    chk("post_rst_state", 32'(dut.state), 32'(IDLE));
    chk("post_rst_ack", sec_ack, 0);

    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("cpu_st_we", mem_en_write, 1);
    chk("cpu_st_addr", 32'(mem_addr), 32'h10);
    chk("cpu_st_data", mem_data_in, 32'hDEADBEEF);
    chk("cpu_st_stall", cpu_stall, 0);
    tick();
    cpu_wr = 0;
    #1;
    chk("cpu_ld_data", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_ld_we", mem_en_write, 0);
    tick();

    cpu_req = 0; sec_req = 1; sec_wr = 0; sec_addr = 32'h40;
    sb.push_back(32'hDEADBEEF);
    #1;
    chk("rd_idle_ack", sec_ack, 0);
    tick();
    chk("rd_gnt_addr", 32'(mem_addr), 32'h10);
    chk("rd_gnt_we", mem_en_write, 0);
    chk("rd_gnt_ack", sec_ack, 0);
    tick();
    chk("rd_ack", sec_ack, 1);
    sec_req = 0;
    tick();
    chk("rd_ack_pulse", sec_ack, 0);

    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h100;
    sec_req = 1; sec_wr = 1; sec_addr = 32'h80; sec_wdata = 32'h55;
    sb.push_back(32'h0);
    #1;
    chk("stv_idle_stall", cpu_stall, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stv_wait_stall", cpu_stall, 0);
      chk("stv_wait_addr", 32'(mem_addr), 32'h40);
      chk("stv_wait_we", mem_en_write, 0);
    end
    tick();
    chk("stv_gnt_stall", cpu_stall, 1);
    chk("stv_gnt_we", mem_en_write, 1);
    chk("stv_gnt_addr", 32'(mem_addr), 32'h20);
    chk("stv_gnt_data", mem_data_in, 32'h55);
    tick();
    chk("stv_ack", sec_ack, 1);
    chk("stv_ack_stall", cpu_stall, 0);
    sec_req = 0; cpu_addr = 32'h80;
    #1;
    chk("stv_readback", cpu_rdata, 32'h55);
    tick();

    cpu_req = 0; sec_req = 1; sec_wr = 1; sec_addr = 32'hF000_0000; sec_wdata = 32'hAB;
    sb.push_back(32'h0);
    tick();
    chk("mmio_gnt_we", mem_en_write, MMIO_WE);
    tick();
    chk("mmio_ack", sec_ack, 1);
    sec_req = 0;
    tick();

    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h40; sec_req = 1; sec_wr = 1; sec_addr = 32'h84; sec_wdata = 32'h77;
    tick();
    tick();
    tick();
    chk("drop_cnt_running", 32'(dut.u_starve.cnt), 32'd2);
    chk("drop_we", mem_en_write, 0);
    sec_req = 0;
    #1;
    chk("drop_no_gnt_we", mem_en_write, 0);
    tick();
    chk("drop_state", 32'(dut.state), 32'(IDLE));
    chk("drop_cnt_clear", 32'(dut.u_starve.cnt), 32'd0);
    chk("drop_ack", sec_ack, 0);
    tick();
    chk("drop_ack_late", sec_ack, 0);
    chk("drop_mem_untouched", mem[8'h21], 32'h0);
    cpu_req = 0;
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
